// File: rtl/display_scan_controller.sv
// Three-digit scanned 7-segment front end: load/busy capture of a 10-bit value,
// iterative double-dabble BCD conversion, and a one-hot digit refresh scheduler.
module display_scan_controller #(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] num,
    input  logic       load,
    output logic       busy,
    output logic [6:0] segments,
    output logic [2:0] digit_en,
    output logic       overflow
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        busy_r;
    logic [9:0]  bin_r;
    logic [11:0] bcd_r;
    logic [3:0]  iter_r;
    logic        over_cap_r;

    logic [3:0]  ones_r;
    logic [3:0]  tens_r;
    logic [3:0]  hund_r;
    logic        overflow_r;

    logic [3:0]  ones_nxt_s;
    logic [3:0]  tens_nxt_s;
    logic [3:0]  hund_nxt_s;
    logic        overflow_nxt_s;

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [1:0]    idx_nxt_s;
    logic          wrap_s;
    logic [6:0]    segments_r;
    logic [2:0]    digit_en_r;

    logic [3:0]  sel_digit_s;
    logic        sel_blank_s;
    logic [6:0]  sel_code_s;

    // One double-dabble iteration: correct every nibble >= 5, then shift {bcd, bin} left.
    function automatic logic [21:0] dabble_step(input logic [11:0] bcd, input logic [9:0] bin);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = bcd[i*4 +: 4];
            end
        end
        return {adj[10:0], bin, 1'b0};
    endfunction

    // Segment pattern (gfedcba) for a single BCD digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b0111111;
            4'd1:    code = 7'b0000110;
            4'd2:    code = 7'b1011011;
            4'd3:    code = 7'b1001111;
            4'd4:    code = 7'b1100110;
            4'd5:    code = 7'b1101101;
            4'd6:    code = 7'b1111101;
            4'd7:    code = 7'b0000111;
            4'd8:    code = 7'b1111111;
            4'd9:    code = 7'b1101111;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Converter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Converter next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_nxt_s = CONVERT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONVERT: begin
                if (iter_r == 4'd9) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = CONVERT;
                end
            end
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Conversion datapath: capture on load, iterate while converting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            bin_r      <= 10'd0;
            bcd_r      <= 12'd0;
            iter_r     <= 4'd0;
            over_cap_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (load) begin
                        bin_r      <= num;
                        bcd_r      <= 12'd0;
                        iter_r     <= 4'd0;
                        over_cap_r <= (num > 10'd999);
                    end
                end
                CONVERT: begin
                    {bcd_r, bin_r} <= dabble_step(bcd_r, bin_r);
                    iter_r         <= iter_r + 4'd1;
                end
                default: begin
                    iter_r <= 4'd0;
                end
            endcase
        end
    end

    // Values the display registers will hold after this edge; only COMMIT changes them.
    always_comb begin
        ones_nxt_s     = ones_r;
        tens_nxt_s     = tens_r;
        hund_nxt_s     = hund_r;
        overflow_nxt_s = overflow_r;
        if (state_r == COMMIT) begin
            ones_nxt_s     = bcd_r[3:0];
            tens_nxt_s     = bcd_r[7:4];
            hund_nxt_s     = bcd_r[11:8];
            overflow_nxt_s = over_cap_r;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Committed display digits and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_r     <= 4'd0;
            tens_r     <= 4'd0;
            hund_r     <= 4'd0;
            overflow_r <= 1'b0;
        end else begin
            ones_r     <= ones_nxt_s;
            tens_r     <= tens_nxt_s;
            hund_r     <= hund_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    // Scan position sequencing: advance 0->1->2->0 on each counter wrap.
    always_comb begin
        wrap_s    = (cnt_r == CNT_MAX);
        idx_nxt_s = idx_r;
        if (wrap_s) begin
            if (idx_r == 2'd2) begin
                idx_nxt_s = 2'd0;
            end else begin
                idx_nxt_s = idx_r + 2'd1;
            end
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Pattern for the position being entered, using the post-commit digits so a
    // commit coinciding with an advance is shown immediately.
    always_comb begin
        sel_digit_s = ones_nxt_s;
        sel_blank_s = 1'b0;
        case (idx_nxt_s)
            2'd0: begin
                sel_digit_s = ones_nxt_s;
                sel_blank_s = 1'b0;
            end
            2'd1: begin
                sel_digit_s = tens_nxt_s;
                sel_blank_s = (hund_nxt_s == 4'd0) && (tens_nxt_s == 4'd0);
            end
            2'd2: begin
                sel_digit_s = hund_nxt_s;
                sel_blank_s = (hund_nxt_s == 4'd0);
            end
            default: begin
                sel_digit_s = ones_nxt_s;
                sel_blank_s = 1'b0;
            end
        endcase
        if (overflow_nxt_s) begin
            sel_code_s = SEG_DASH;
        end else if (BLANK_LEADING && sel_blank_s) begin
            sel_code_s = SEG_BLANK;
        end else begin
            sel_code_s = seg_code(sel_digit_s);
        end
    end

    // Refresh counter, scan index and the registered segment/enable outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= CNT_ZERO;
            idx_r      <= 2'd0;
            segments_r <= SEG_ZERO;
            digit_en_r <= 3'b001;
        end else begin
            idx_r <= idx_nxt_s;
            if (wrap_s) begin
                cnt_r      <= CNT_ZERO;
                segments_r <= sel_code_s;
                digit_en_r <= 3'b001 << idx_nxt_s;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign busy     = busy_r;
    assign segments = segments_r;
    assign digit_en = digit_en_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed + randomized bench for display_scan_controller: one instance with
// leading-zero blanking and one without, both compared against an arithmetic model.
module tb_display_scan_controller;

    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [9:0] num;

    logic       busy_b, busy_f;
    logic [6:0] seg_b, seg_f;
    logic [2:0] en_b, en_f;
    logic       ovf_b, ovf_f;

    int checks = 0;
    int errors = 0;
    int k;

    display_scan_controller #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) u_blank (
        .clk(clk), .rst(rst), .num(num), .load(load),
        .busy(busy_b), .segments(seg_b), .digit_en(en_b), .overflow(ovf_b)
    );

    display_scan_controller #(.SCAN_DIV(SD), .BLANK_LEADING(1'b0)) u_full (
        .clk(clk), .rst(rst), .num(num), .load(load),
        .busy(busy_f), .segments(seg_f), .digit_en(en_f), .overflow(ovf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges elapsed since reset was released: scan position is (k / SD) % 3.
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit bl);
        int d;
        if (v > 999) return 7'b1000000;
        d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
        if (bl && ((pos == 2 && v < 100) || (pos == 1 && v < 10))) return 7'b0000000;
        return digit_code(d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_busy(input logic exp);
        check("busy_blank", {31'd0, busy_b}, {31'd0, exp});
        check("busy_full",  {31'd0, busy_f}, {31'd0, exp});
    endtask

    task automatic check_reset_outputs();
        check_busy(1'b0);
        check("rst_en_blank",  {29'd0, en_b}, 32'd1);
        check("rst_en_full",   {29'd0, en_f}, 32'd1);
        check("rst_seg_blank", {25'd0, seg_b}, 32'h3f);
        check("rst_seg_full",  {25'd0, seg_f}, 32'h3f);
        check("rst_ovf_blank", {31'd0, ovf_b}, 32'd0);
        check("rst_ovf_full",  {31'd0, ovf_f}, 32'd0);
    endtask

    // One full refresh frame, every cycle compared against the model.
    task automatic check_frame(input int v);
        int pos;
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            pos = (k / SD) % 3;
            check("en_blank",  {29'd0, en_b}, 32'd1 << pos);
            check("en_full",   {29'd0, en_f}, 32'd1 << pos);
            check("seg_blank", {25'd0, seg_b}, {25'd0, exp_seg(v, pos, 1'b1)});
            check("seg_full",  {25'd0, seg_f}, {25'd0, exp_seg(v, pos, 1'b0)});
            check("ovf_blank", {31'd0, ovf_b}, {31'd0, (v > 999)});
            check("ovf_full",  {31'd0, ovf_f}, {31'd0, (v > 999)});
        end
    endtask

    // Load v, verify busy for exactly 11 cycles (optionally pulsing a rejected load), then the display.
    task automatic load_and_check(input int v, input bit pulse);
        @(negedge clk);
        num  = 10'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        num  = 10'($urandom_range(0, 1023));
        check_busy(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pulse && i == 3) begin
                num  = 10'd600;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            check_busy(1'b1);
        end
        load = 1'b0;
        @(negedge clk);
        check_busy(1'b0);
        check("ovf_commit_blank", {31'd0, ovf_b}, {31'd0, (v > 999)});
        check("ovf_commit_full",  {31'd0, ovf_f}, {31'd0, (v > 999)});
        repeat (3 * SD) @(negedge clk);
        check_frame(v);
    endtask

    initial begin
        int v;
        bit done;
        load = 1'b0;
        num  = 10'd0;
        rst  = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_frame(0);

        load_and_check(123, 1'b0);
        load_and_check(7, 1'b0);
        load_and_check(1000, 1'b0);
        load_and_check(1023, 1'b0);
        load_and_check(999, 1'b0);
        load_and_check(45, 1'b1);

        // load held high: the request right after busy falls starts a new conversion
        @(negedge clk);
        num  = 10'd100;
        load = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            num = 10'd200;
            check_busy(1'b1);
        end
        @(negedge clk);
        check_busy(1'b0);
        @(negedge clk);
        load = 1'b0;
        check_busy(1'b1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!busy_b && !busy_f) done = 1'b1;
        end
        check("b2b_idle_timeout", {31'd0, done}, 32'd1);
        repeat (3 * SD) @(negedge clk);
        check_frame(200);

        // reset during the fifth conversion iteration
        @(negedge clk);
        num  = 10'd512;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        check_frame(0);
        load_and_check(512, 1'b0);

        for (int i = 0; i < 10; i++) begin
            v = (i % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 1023));
            load_and_check(v, (i % 4 == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequential front end for the board's three-digit 7-segment display. It accepts a 10-bit binary result, such as a serial adder sum, through a load/busy handshake. It converts the value to three BCD digits with an iterative shift-add-3 (double-dabble) engine, then time-multiplexes the digits onto one shared segment bus with a one-hot digit enable. This replaces three static decoders with one decoder plus a refresh scheduler, for common-cathode scanned displays.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each digit stays enabled. Legal when ≥ 2.
- BLANK_LEADING, default 1: when 1, leading zero digits are blanked. When 0, all three digits are always shown.

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- num  in  10  binary value to display, 0..1023.
- load  in  1  request to capture num. Sampled only while busy=0.
- busy  out  1  high while a conversion is in progress.
- segments  out  7  active-high segments in bit order gfedcba (bit0 = a), registered.
- digit_en  out  3  one-hot digit enable, registered. bit0 = ones, bit1 = tens, bit2 = hundreds.
- overflow  out  1  high when the committed value exceeds 999, registered.

## Operation
- Segment code table (digit → segments):
  - 0 → 0111111, 1 → 0000110, 2 → 1011011, 3 → 1001111, 4 → 1100110
  - 5 → 1101101, 6 → 1111101, 7 → 0000111, 8 → 1111111, 9 → 1101111
  - blank → 0000000, dash → 1000000
- Converter FSM states:
  - IDLE: busy=0. When load=1, capture num into a shift register, clear the 12-bit BCD accumulator and go to CONVERT.
  - CONVERT: runs exactly 10 iterations. Each iteration adds 3 to any BCD nibble ≥ 5, then shifts {bcd, bin} left by 1.
  - COMMIT: one cycle. Writes the display digit registers and overflow, then returns to IDLE.
- Overflow rule: if the captured num > 999, set overflow=1 and show dash on all three digits. Otherwise overflow=0 and the digits are the BCD result.
- Display registers change only in COMMIT, so the display keeps the old value during a conversion (no tearing).
- load asserted while busy=1 is ignored; it is not queued.
- Scan scheduler:
  - A counter runs 0..SCAN_DIV-1 continuously and independently of the converter.
  - On wrap, the digit index advances 0→1→2→0.
  - digit_en = 1 << index. segments = code of the indexed digit.
- Blanking, when BLANK_LEADING=1:
  - Hundreds is blanked if it is 0.
  - Tens is blanked if hundreds and tens are both 0.
  - Ones is never blanked.
  - Blanking never applies while overflow=1.

## Timing
- Reset values: busy=0, FSM=IDLE, digit_en=3'b001, scan counter=0, overflow=0, committed digits=0,0,0, segments=7'b0111111 (ones digit shows 0).
- Handshake:
  - load=1 sampled at edge T while IDLE.
  - busy is high from after edge T through edge T+11. CONVERT covers edges T+1..T+10; COMMIT is at edge T+11.
  - busy is low after edge T+11, and a new load is accepted at edge T+12.
  - Total latency is 11 cycles from the sampling edge to the committed digits.
- New digits first appear on segments at the next scan advance after COMMIT, or at that same edge if it coincides with the advance.
- Each digit_en pattern holds for exactly SCAN_DIV cycles. segments and digit_en change on the same edge. A full refresh frame is 3·SCAN_DIV cycles.
- A COMMIT on the same edge as a scan advance uses the newly committed digits for the newly selected position.
- rst asserted mid-conversion:
  - Aborts the conversion immediately (asynchronously).
  - Restores all reset values, and the display shows 0.
  - No partial result is ever committed.
- num is sampled only at the load edge; later changes to num do not affect an ongoing conversion.

## Test plan
- Reset: assert rst mid-stream → busy=0, digit_en=001, segments=0111111, overflow=0 without waiting for a clock edge.
- Basic conversion (SCAN_DIV=4): load num=123 → busy high for exactly 11 cycles. Then the scan shows:
  - digit_en=001 with segments=1001111 (digit 3)
  - digit_en=010 with segments=1011011 (digit 2)
  - digit_en=100 with segments=0000110 (digit 1)
  - each pattern lasts 4 cycles.
- Blanking: load num=7 with BLANK_LEADING=1 → ones=0000111, tens and hundreds=0000000. Repeat load num=7 with BLANK_LEADING=0 → tens and hundreds=0111111.
- Overflow: load num=1000, then num=1023 → overflow=1 and all three digits show 1000000. Then load num=999 → overflow=0, digits 9,9,9 (1101111).
- Handshake: load num=45, pulse load with num=600 during busy → the committed value is 45. Loads issued in back-to-back cycles after busy falls are both accepted.
- Reset mid-conversion: load num=512, assert rst at cycle 5 of CONVERT, release it → the display shows 0 and a subsequent load of 512 completes correctly.
